// File: rtl/loop_counter_if.sv
// Handshake/data bundle between a loop controller (master) and loop_counter (slave).
interface loop_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] limit;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, init_val, limit, pause,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, init_val, limit, pause,
    output count, busy, done, wrap
  );
endinterface

// File: rtl/loop_counter.sv
// Loop counter stage: holds the count, feeds it through a +1 incrementer and
// writes the result back until the captured limit is reached.
// Optional macro LOOP_COUNTER_AUTORELOAD_EN: a start seen in DONE begins the next
// loop directly, leaving one dead cycle between back-to-back loops.
module loop_counter #(
  parameter int unsigned WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  loop_counter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   inc_sum;
  logic             inc_carry;
  logic             accept;

  // Incrementer datapath: X = count, S = low bits, carry-out marks the wrap
  always_comb begin
    inc_sum   = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    inc_carry = inc_sum[WIDTH];
  end

  // A new loop may be accepted in IDLE (and in DONE when autoreload is built in)
  always_comb begin
`ifdef LOOP_COUNTER_AUTORELOAD_EN
    accept = bus.start && ((state_q == StIdle) || (state_q == StDone));
`else
    accept = bus.start && (state_q == StIdle);
`endif
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        // Terminal-count check wins over pause
        if (count_q == limit_q) begin
          state_d = StDone;
        end else if (bus.pause) begin
          state_d = StPause;
        end else begin
          count_d = inc_sum[WIDTH-1:0];
          if (inc_carry) wrap_d = 1'b1;
        end
      end
      StPause: begin
        // Return cycle does not increment
        if (!bus.pause) state_d = StRun;
      end
      StDone: begin
        state_d = accept ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      count_d = bus.init_val;
      limit_d = bus.limit;
      wrap_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      limit_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.count = count_q;
    bus.busy  = (state_q == StRun) || (state_q == StPause);
    bus.done  = (state_q == StDone);
    bus.wrap  = wrap_q;
  end

endmodule

// File: tb/tb_loop_counter.sv
// Self-checking bench for loop_counter: per-cycle comparison against a
// transaction-level model plus literal latency/final-value expectations.
module tb_loop_counter;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  loop_counter_if #(.WIDTH(WIDTH)) bus ();

  loop_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  // Model: a loop is "active" from accepted start until count reaches the limit
  logic [WIDTH-1:0] m_count;
  logic [WIDTH-1:0] m_lim;
  bit               m_wrap, m_active, m_held, m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = '0; m_lim = '0; m_wrap = 0; m_active = 0; m_held = 0; m_done = 0;
    end else begin
      bit can_start;
`ifdef LOOP_COUNTER_AUTORELOAD_EN
      can_start = !m_active;
`else
      can_start = !m_active && !m_done;
`endif
      if (m_active && m_held) begin
        if (!bus.pause) m_held = 0;
      end else if (m_active) begin
        if (m_count == m_lim) begin
          m_active = 0;
          m_done = 1;
        end else if (bus.pause) begin
          m_held = 1;
        end else begin
          m_wrap = m_wrap | (m_count == {WIDTH{1'b1}});
          m_count = m_count + 1'b1;
        end
      end else begin
        m_done = 0;
      end
      if (can_start && bus.start) begin
        m_count = bus.init_val; m_lim = bus.limit; m_wrap = 0; m_active = 1; m_done = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(bus.count), int'(m_count));
      check("busy", int'(bus.busy), int'(m_active));
      check("done", int'(bus.done), int'(m_done));
      check("wrap", int'(bus.wrap), int'(m_wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse start for one edge; returns the number of the accepting edge
  task automatic go(input int iv, input int lm, output int s_cyc);
    bus.start = 1'b1;
    bus.init_val = WIDTH'(iv);
    bus.limit = WIDTH'(lm);
    tick();
    s_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int d_cyc);
    bit found = 0;
    d_cyc = -1;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found = 1;
        d_cyc = cyc;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  initial begin
    int s, d, d0, c1, c2;
    bit hit;
    bus.start = 1'b0; bus.init_val = '0; bus.limit = '0; bus.pause = 1'b0;
    tick();
    chk_en = 1'b1;
    check("rst_count", int'(bus.count), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-loop at count 5
    d0 = done_cnt;
    go(2, 9, s);
    hit = 0;
    for (int i = 0; i < 32 && !hit; i++) begin
      @(negedge clk);
      if (bus.count == 4'd5) hit = 1;
    end
    check("midreset_reach5", int'(hit), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_count", int'(bus.count), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_wrap", int'(bus.wrap), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("midreset_nodone", done_cnt - d0, 0);

    // Basic loop 3..7: D=4, done after edge s+5
    d0 = done_cnt;
    go(3, 7, s);
    wait_done("basic", d);
    check("basic_latency", d - s, 5);
    check("basic_wrap", int'(bus.wrap), 0);
    tick(); tick(); tick();
    check("basic_final", int'(bus.count), 7);
    check("basic_pulses", done_cnt - d0, 1);

    // Wrap 14,15,0,1: D=3
    d0 = done_cnt;
    go(14, 1, s);
    wait_done("wrap", d);
    check("wrap_latency", d - s, 4);
    check("wrap_flag", int'(bus.wrap), 1);
    tick(); tick();
    check("wrap_final", int'(bus.count), 1);
    check("wrap_flag_held", int'(bus.wrap), 1);
    check("wrap_pulses", done_cnt - d0, 1);

    // init == limit: no increment
    go(5, 5, s);
    wait_done("equal", d);
    check("equal_latency", d - s, 1);
    check("equal_count", int'(bus.count), 5);
    tick(); tick();

    // start while busy is ignored
    go(1, 6, s);
    tick();
    bus.start = 1'b1; bus.init_val = 4'd0; bus.limit = 4'd3;
    tick(); tick();
    bus.start = 1'b0;
    wait_done("ignored", d);
    check("ignored_latency", d - s, 6);
    check("ignored_count", int'(bus.count), 6);
    tick(); tick();

    // Pause at count 2 for three sampled edges: those three plus the
    // non-incrementing return cycle add 4 edges to the nominal 5
    go(0, 4, s);
    tick(); tick();
    bus.pause = 1'b1;
    tick();
    check("pause_hold_busy", int'(bus.busy), 1);
    tick(); tick();
    bus.pause = 1'b0;
    check("pause_hold_count", int'(bus.count), 2);
    wait_done("pause", d);
    check("pause_latency", d - s, 9);
    check("pause_count", int'(bus.count), 4);
    tick(); tick();

    // Held start: loops repeat; period between done pulses shows reload gap
    bus.start = 1'b1; bus.init_val = 4'd0; bus.limit = 4'd2;
    tick();
    wait_done("reload1", c1);
    wait_done("reload2", c2);
    bus.start = 1'b0;
`ifdef LOOP_COUNTER_AUTORELOAD_EN
    check("reload_period", c2 - c1, 4);
`else
    check("reload_period", c2 - c1, 5);
`endif
    tick(); tick(); tick();
    check("reload_idle_busy", int'(bus.busy), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
